// File: rtl/servo_pwm_generator.sv
// Servo PWM generator: 1024-step period, duty latched and clamped at period boundaries.
// Optional per-period slew limiting is enabled by defining SERVO_SLEW_EN.
module servo_pwm_generator #(
  parameter int unsigned Prescale = 488,
  parameter int unsigned MinDuty  = 26,
  parameter int unsigned MaxDuty  = 128,
  parameter int unsigned Neutral  = 77
`ifdef SERVO_SLEW_EN
  ,
  parameter int unsigned SlewStep = 4
`endif
) (
  input  logic       clk25mhz,
  input  logic       reset,
  input  logic [9:0] duty_cycle_input,
  input  logic       enable,
  output logic       servoSignal,
  output logic       period_start,
  output logic [9:0] duty_active
);

  localparam int unsigned    PsW     = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [PsW-1:0] PsLast  = PsW'(Prescale - 1);
  localparam logic [9:0]     MinD    = 10'(MinDuty);
  localparam logic [9:0]     MaxD    = 10'(MaxDuty);
  localparam logic [9:0]     NeutD   = 10'(Neutral);
  localparam logic [9:0]     PhLast  = 10'd1023;

  logic [PsW-1:0] prescaler_q, prescaler_d;
  logic [9:0]     phase_q, phase_d;
  logic [9:0]     duty_q, duty_d;
  logic           en_q, en_d;
  logic           servo_q, servo_d;
  logic           ps_q, ps_d;

  logic           tick;
  logic           boundary;
  logic [9:0]     next_duty;
  logic [9:0]     duty_new;

  assign tick     = (prescaler_q == PsLast);
  assign boundary = tick && (phase_q == PhLast);

  always_comb begin
    next_duty = duty_cycle_input;
    if (duty_cycle_input < MinD) begin
      next_duty = MinD;
    end else if (duty_cycle_input > MaxD) begin
      next_duty = MaxD;
    end
  end

`ifdef SERVO_SLEW_EN
  localparam logic signed [10:0] Step  = 11'(SlewStep);
  localparam logic [9:0]         StepU = 10'(SlewStep);

  logic signed [10:0] diff;

  // Move toward the clamped command by at most one step, landing exactly when close enough.
  always_comb begin
    diff     = $signed({1'b0, next_duty}) - $signed({1'b0, duty_q});
    duty_new = next_duty;
    if (diff > Step) begin
      duty_new = duty_q + StepU;
    end else if (diff < -Step) begin
      duty_new = duty_q - StepU;
    end
  end
`else
  assign duty_new = next_duty;
`endif

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    phase_d     = tick ? phase_q + 10'd1 : phase_q;
    duty_d      = boundary ? duty_new : duty_q;
    en_d        = boundary ? enable : en_q;
    ps_d        = boundary;
    // Registered compare keeps the output glitch-free; a new duty only lands at phase 0.
    servo_d     = en_q && (phase_q < duty_q);
  end

  always_ff @(posedge clk25mhz or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      phase_q     <= '0;
      duty_q      <= NeutD;
      en_q        <= 1'b0;
      servo_q     <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      phase_q     <= phase_d;
      duty_q      <= duty_d;
      en_q        <= en_d;
      servo_q     <= servo_d;
      ps_q        <= ps_d;
    end
  end

  assign servoSignal  = servo_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Randomized scoreboard bench for servo_pwm_generator with a reduced prescaler.
// Expected per-period duty and high time come from a plain arithmetic model of the boundary rules.
module tb_servo_pwm_generator;

  localparam int Prescale = 2;
  localparam int PeriodL  = 1024 * Prescale;
  localparam int MinD     = 26;
  localparam int MaxD     = 128;
  localparam int Neut     = 77;
  localparam int Slew     = 4;

  typedef struct {
    int duty;
    int high;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] duty_cycle_input = 10'd0;
  logic       enable = 1'b0;
  logic       servoSignal;
  logic       period_start;
  logic [9:0] duty_active;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   m_duty;
  bit   m_en;

  servo_pwm_generator #(
    .Prescale(Prescale)
  ) dut (
    .clk25mhz        (clk),
    .reset           (reset),
    .duty_cycle_input(duty_cycle_input),
    .enable          (enable),
    .servoSignal     (servoSignal),
    .period_start    (period_start),
    .duty_active     (duty_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampd(input int x);
    if (x < MinD) return MinD;
    if (x > MaxD) return MaxD;
    return x;
  endfunction

  // Reference: what the boundary does with the command present at it.
  task automatic model_boundary(input int cmd, input bit en);
    int target;
    exp_t e;
    target = clampd(cmd);
`ifdef SERVO_SLEW_EN
    if (target > m_duty) m_duty = (target - m_duty > Slew) ? m_duty + Slew : target;
    else m_duty = (m_duty - target > Slew) ? m_duty - Slew : target;
`else
    m_duty = target;
`endif
    m_en   = en;
    e.duty = m_duty;
    e.high = m_en ? m_duty * Prescale : 0;
    exp_q.push_back(e);
  endtask

  // One period of stimulus: a random junk command, then the final one that the boundary sees.
  task automatic run_period(input int final_duty, input bit final_en);
    int a;
    int b;
    a = $urandom_range(0, PeriodL - 3);
    b = $urandom_range(a + 1, PeriodL - 1);
    for (int c = 0; c < PeriodL; c++) begin
      if (c == a) begin
        duty_cycle_input = 10'($urandom_range(0, 1023));
        enable           = 1'($urandom_range(0, 1));
      end
      if (c == b) begin
        duty_cycle_input = 10'(final_duty);
        enable           = final_en;
        model_boundary(final_duty, final_en);
      end
      @(negedge clk);
    end
  endtask

  // Monitor: measures each period and compares against the head of the queue at period_start.
  initial begin
    int   cnt;
    int   high;
    int   rises;
    int   cur_high;
    bit   prev;
    exp_t e;
    cnt = 0; high = 0; rises = 0; cur_high = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; high = 0; rises = 0; cur_high = 0; prev = 1'b0;
        exp_q.delete();
      end else begin
        cnt++;
        if (servoSignal) high++;
        if (servoSignal && !prev) rises++;
        prev = servoSignal;
        if (period_start) begin
          check("period_spacing", cnt, PeriodL);
          check("high_cycles", high, cur_high);
          check("pulse_count", rises, (cur_high > 0) ? 1 : 0);
          if (exp_q.size() == 0) begin
            check("queue_underflow", 1, 0);
            cur_high = 0;
          end else begin
            e = exp_q.pop_front();
            check("duty_active", int'(duty_active), e.duty);
            cur_high = e.high;
          end
          cnt = 0; high = 0; rises = 0;
        end else if (cnt > PeriodL + 4) begin
          check("period_timeout", cnt, PeriodL);
          cnt = 0;
        end
      end
    end
  end

  initial begin
    int d1[8] = '{77, 51, 92, 0, 1023, 60, 100, 70};
    bit e1[8] = '{1, 1, 1, 1, 1, 0, 0, 1};
    m_duty = Neut;
    m_en   = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_servo", int'(servoSignal), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_duty_active", int'(duty_active), Neut);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_period(d1[i], e1[i]);

    // Period with duty 70 enabled is now running; reset in the middle of its pulse.
    repeat (20) @(negedge clk);
    check("pulse_mid", int'(servoSignal), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_servo", int'(servoSignal), 0);
    check("async_rst_duty", int'(duty_active), Neut);
    check("async_rst_ps", int'(period_start), 0);
    m_duty = Neut;
    m_en   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_period(92, 1'b1);
    run_period(51, 1'b1);
    for (int i = 0; i < 5; i++) run_period($urandom_range(0, 1023), 1'($urandom_range(0, 1)));

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
